// File: rtl/hex_scan.sv
// Time-multiplexed scanner for common-anode 7-segment digits, feeding a hex decoder.
// Optional leading-zero blanking is enabled by defining HEX_SCAN_LZ_BLANK_EN.
module hex_scan #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int GUARD  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic                  load,
  output logic                  pending,
  output logic [3:0]            data,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   disp;
  logic [4*DIGITS-1:0]   pend_val;

  logic tick;
  logic wrap;
  logic guard_on;
  logic lit;

  assign tick = (presc == PW'(DIV - 1));
  assign wrap = tick && (idx == IW'(DIGITS - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      idx      <= '0;
      disp     <= '0;
      pend_val <= '0;
      pending  <= 1'b0;
      frame    <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick)
        idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      frame <= wrap;
      // Commit uses the pend_val held before this edge; a coincident load re-arms pending.
      if (wrap && pending)
        disp <= pend_val;
      if (load) begin
        pend_val <= value_in;
        pending  <= 1'b1;
      end else if (wrap) begin
        pending  <= 1'b0;
      end
    end
  end

  // NOTE: combinational blocks assign a default first so no path can infer a latch.
  always_comb begin
    data = '0;
    for (int i = 0; i < DIGITS; i++)
      if (idx == IW'(i))
        data = disp[4*i +: 4];
  end

  generate
    if (GUARD > 0) begin : g_guard
      assign guard_on = (presc < PW'(GUARD));
    end else begin : g_no_guard
      assign guard_on = 1'b0;
    end
  endgenerate

`ifdef HEX_SCAN_LZ_BLANK_EN
  logic [DIGITS-1:0] shown;

  // A digit is shown if it or any more-significant digit is nonzero; digit 0 always shows.
  always_comb begin
    logic seen;
    seen  = 1'b0;
    shown = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen     = seen | (|disp[4*i +: 4]);
      shown[i] = seen | (i == 0);
    end
  end

  assign lit = shown[idx];
`else
  assign lit = 1'b1;
`endif

  always_comb begin
    an = '1;
    if (!guard_on && lit)
      for (int i = 0; i < DIGITS; i++)
        an[i] = (idx != IW'(i));
  end

endmodule

// File: tb/tb_hex_scan.sv
// Self-checking bench for hex_scan: directed scenarios plus random loads/resets against a
// cycle-count based reference model. Honours HEX_SCAN_LZ_BLANK_EN like the design.
module tb_hex_scan;

  localparam int DIGITS = 4;
  localparam int DIV    = 8;
  localparam int GUARD  = 2;
  localparam int FRAME  = DIGITS * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value_in = '0;
  logic        load = 1'b0;
  logic        pending;
  logic [3:0]  data;
  logic [3:0]  an;
  logic        frame;

  hex_scan #(.DIGITS(DIGITS), .DIV(DIV), .GUARD(GUARD)) dut (
    .clk      (clk),
    .rst      (rst),
    .value_in (value_in),
    .load     (load),
    .pending  (pending),
    .data     (data),
    .an       (an),
    .frame    (frame)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: position in the scan follows from cycles since reset.
  int          cyc = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;
  logic        m_pending = 1'b0;
  logic        m_frame = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, exp);
  endtask

  function automatic logic [3:0] exp_an();
    int p, ix, h;
    logic [3:0] r;
    p  = cyc % DIV;
    ix = (cyc / DIV) % DIGITS;
    h  = 0;
    for (int i = 0; i < DIGITS; i++)
      if (m_disp[4*i +: 4] != 4'h0) h = i;
    r = (p < GUARD) ? 4'hF : ~(4'b0001 << ix);
`ifdef HEX_SCAN_LZ_BLANK_EN
    if (ix > h) r = 4'hF;
`endif
    return r;
  endfunction

  task automatic step(input logic ld, input logic [15:0] v, input logic r);
    int ix;
    load = ld; value_in = v; rst = r;
    @(posedge clk);
    if (r) begin
      cyc = 0; m_disp = '0; m_pend = '0; m_pending = 1'b0; m_frame = 1'b0;
    end else begin
      cyc++;
      m_frame = (cyc % FRAME) == 0;
      if (m_frame && m_pending) begin
        m_disp    = m_pend;
        m_pending = 1'b0;
      end
      if (ld) begin
        m_pend    = v;
        m_pending = 1'b1;
      end
    end
    #1;
    ix = (cyc / DIV) % DIGITS;
    check("an", 32'(an), 32'(exp_an()));
    check("data", 32'(data), 32'(m_disp[4*ix +: 4]));
    check("pending", 32'(pending), 32'(m_pending));
    check("frame", 32'(frame), 32'(m_frame));
    load = 1'b0; rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  // Idle until the pre-edge scan position (cyc mod FRAME) equals pos; bounded by one frame.
  task automatic run_until(input int pos);
    for (int i = 0; i < FRAME && (cyc % FRAME) != pos; i++) step(1'b0, '0, 1'b0);
  endtask

  initial begin
    // Reset and a blank frame with only the guard/anode sweep running.
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    idle(32);

    // Load at presc=3, idx=1, then watch the commit and the next frame.
    run_until(11);
    step(1'b1, 16'h1234, 1'b0);
    idle(2 * FRAME);

    // Last load before the wrap wins.
    run_until(5);
    step(1'b1, 16'h1111, 1'b0);
    idle(3);
    step(1'b1, 16'hABCD, 1'b0);
    idle(2 * FRAME);

    // Load coincident with the wrap edge and pending=0: commits one frame later.
    run_until(FRAME - 1);
    step(1'b1, 16'h00F0, 1'b0);
    check("no_early_commit", 32'(data), 32'(4'hD));
    idle(FRAME + 6);
    check("late_commit_pending", 32'(pending), 32'(1'b0));

    // Reset mid-frame with a value pending discards it.
    step(1'b1, 16'h5555, 1'b0);
    run_until(2 * DIV + 1);
    step(1'b0, '0, 1'b1);
    check("rst_discards", 32'(pending), 32'(1'b0));
    idle(FRAME + 4);

    // Leading-zero cases and an all-zero value.
    step(1'b1, 16'h0040, 1'b0);
    idle(2 * FRAME);
    step(1'b1, 16'h0000, 1'b0);
    idle(2 * FRAME);

    // Randomized loads and occasional resets, all checked against the model.
    for (int i = 0; i < 4000; i++) begin
      logic [15:0] v;
      logic        ld, r;
      v  = 16'($urandom);
      if ($urandom_range(0, 1) == 0)
        v = v & (16'hFFFF >> (4 * $urandom_range(0, 3)));
      ld = ($urandom_range(0, 19) == 0);
      r  = ($urandom_range(0, 399) == 0);
      step(ld, v, r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
